// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the unified-memory port arbiter.
// Holds the FSM state type, the latency counter width and the MEM_LAT legality check.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } arb_state_e;

    // The counter must be able to hold the full latency value at grant time.
    function automatic bit mem_lat_ok(input int unsigned lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX) && (lat < (1 << CNT_W));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter timing the memory read latency; zero flags the capture cycle.
// Saturates at zero so it idles quietly between accesses.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Data has fixed priority; one access is in flight at a time, completed by a valid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] LatLoad = CNT_W'(MEM_LAT);

    arb_state_e        state_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic              grant_dm;
    logic              grant_if;
    logic              cnt_zero;

    // A requester's req is already consumed in its own valid cycle.
    always_comb begin
        grant_dm = (state_q == ST_IDLE) && bus.dm_req && !dm_valid_q;
        grant_if = (state_q == ST_IDLE) && !grant_dm && bus.if_req && !if_valid_q;
    end

    arb_lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_dm || grant_if),
        .load_val (LatLoad),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            store_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        mem_en_q <= 1'b1;
                        mem_we_q <= bus.dm_we;
                        store_q  <= bus.dm_we;
                        addr_q   <= bus.dm_addr;
                        wdata_q  <= bus.dm_wdata;
                        state_q  <= ST_BUSY_DM;
                    end else if (grant_if) begin
                        mem_en_q <= 1'b1;
                        store_q  <= 1'b0;
                        addr_q   <= bus.if_addr;
                        state_q  <= ST_BUSY_IF;
                    end
                end
                ST_BUSY_IF: begin
                    if (cnt_zero) begin
                        if_rdata_q <= bus.mem_rdata;
                        if_valid_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY_DM: begin
                    if (cnt_zero) begin
                        if (!store_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                        dm_valid_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_stall  = bus.if_req && !if_valid_q && !rst;
    assign bus.dm_stall  = bus.dm_req && !dm_valid_q && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard queues hold expected memory issues and
// completions with their cycle numbers; a negedge monitor compares every cycle.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT = 2;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;
    logic prev_en = 1'b0;
    logic [31:0] dm_model = '0;

    exp_t issue_q[$];
    exp_t if_q[$];
    exp_t dm_q[$];

    logic [31:0] mem [0:63];
    logic [31:0] rd_dat [MEM_LAT];
    logic        rd_vld [MEM_LAT];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears MEM_LAT cycles after the mem_en cycle, junk otherwise.
    assign bus.mem_rdata = rd_vld[MEM_LAT-1] ? rd_dat[MEM_LAT-1] : 32'hBADC_0FFE;

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            rd_dat[i] <= rd_dat[i-1];
            rd_vld[i] <= rd_vld[i-1];
        end
        rd_vld[0] <= (bus.mem_en === 1'b1) && (bus.mem_we === 1'b0);
        rd_dat[0] <= mem[bus.mem_addr[7:2]];
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int c, input logic [31:0] a, input logic w,
                                input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.addr = a;
        e.we = w;
        e.data = d;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            exp_t e;
            logic due;
            logic iv;
            logic dv;
            due = (issue_q.size() > 0) && (issue_q[0].cyc == cyc);
            chk("mem_en", bus.mem_en, due);
            chk("mem_en_gap", prev_en & bus.mem_en, 1'b0);
            prev_en = bus.mem_en;
            if (due) begin
                e = issue_q.pop_front();
                chk("mem_addr", bus.mem_addr, e.addr);
                chk("mem_we", bus.mem_we, e.we);
                if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
            end
            iv = (if_q.size() > 0) && (if_q[0].cyc == cyc);
            chk("if_valid", bus.if_valid, iv);
            if (iv) begin
                e = if_q.pop_front();
                chk("if_rdata", bus.if_rdata, e.data);
            end
            dv = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);
            chk("dm_valid", bus.dm_valid, dv);
            if (dv) begin
                e = dm_q.pop_front();
                if (e.we) begin
                    chk("dm_rdata_store", bus.dm_rdata, dm_model);
                end else begin
                    chk("dm_rdata", bus.dm_rdata, e.data);
                    dm_model = e.data;
                end
            end
            chk("if_stall", bus.if_stall, bus.if_req & ~iv & ~rst);
            chk("dm_stall", bus.dm_stall, bus.dm_req & ~dv & ~rst);
        end
    end

    initial begin
        int b;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[4] = 32'hDEAD_BEEF;
        bus.if_req   = 1'b1;
        bus.dm_req   = 1'b1;
        bus.if_addr  = '0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        rst = 1'b1;

        // Reset held for three edges with both requests pending.
        next_cycle();
        mon_on = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("rst_if_rdata", bus.if_rdata, '0);
        chk("rst_dm_rdata", bus.dm_rdata, '0);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        chk("rst_mem_we", bus.mem_we, 1'b0);

        // Single fetch.
        next_cycle();
        b = cyc;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        issue_q.push_back(mk(b + 1, 32'h10, 1'b0, '0));
        if_q.push_back(mk(b + MEM_LAT + 2, 32'h10, 1'b0, 32'hDEAD_BEEF));
        repeat (MEM_LAT + 3) next_cycle();
        bus.if_req = 1'b0;

        // Simultaneous requests: data first, fetch granted in the data valid cycle.
        next_cycle();
        b = cyc;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 32'h40;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h8;
        issue_q.push_back(mk(b + 1, 32'h40, 1'b0, '0));
        issue_q.push_back(mk(b + MEM_LAT + 3, 32'h8, 1'b0, '0));
        dm_q.push_back(mk(b + MEM_LAT + 2, 32'h40, 1'b0, mem[16]));
        if_q.push_back(mk(b + 2 * MEM_LAT + 4, 32'h8, 1'b0, mem[2]));
        repeat (MEM_LAT + 3) next_cycle();
        bus.dm_req = 1'b0;
        repeat (MEM_LAT + 2) next_cycle();
        bus.if_req = 1'b0;

        // Store leaves dm_rdata untouched.
        next_cycle();
        b = cyc;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h20;
        bus.dm_wdata = 32'h1234;
        issue_q.push_back(mk(b + 1, 32'h20, 1'b1, 32'h1234));
        dm_q.push_back(mk(b + MEM_LAT + 2, 32'h20, 1'b1, 32'h1234));
        repeat (MEM_LAT + 3) next_cycle();
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;

        // Reset the cycle after mem_en: the access must never complete.
        next_cycle();
        b = cyc;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h30;
        issue_q.push_back(mk(b + 1, 32'h30, 1'b0, '0));
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("rst2_if_rdata", bus.if_rdata, '0);
        chk("rst2_dm_rdata", bus.dm_rdata, '0);
        chk("rst2_mem_wdata", bus.mem_wdata, '0);
        dm_model = '0;
        next_cycle();
        b = cyc;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h14;
        issue_q.push_back(mk(b + 1, 32'h14, 1'b0, '0));
        if_q.push_back(mk(b + MEM_LAT + 2, 32'h14, 1'b0, mem[5]));
        repeat (MEM_LAT + 3) next_cycle();
        bus.if_req = 1'b0;

        // Back-to-back fetches with if_req held; next address follows each valid.
        next_cycle();
        bus.if_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.if_addr = 32'(4 * k);
            issue_q.push_back(mk(cyc + 1, 32'(4 * k), 1'b0, '0));
            if_q.push_back(mk(cyc + MEM_LAT + 2, 32'(4 * k), 1'b0, mem[k]));
            repeat (MEM_LAT + 3) next_cycle();
        end
        bus.if_req = 1'b0;

        repeat (4) next_cycle();
        chk("issue_q_empty", issue_q.size(), 0);
        chk("if_q_empty", if_q.size(), 0);
        chk("dm_q_empty", dm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
